// File: rtl/simd_operand_loader.sv
// rtl/simd_operand_loader.sv - assembles two SIMD operands from narrow beats and presents them as one registered set
module simd_operand_loader #(
    parameter int SIMD_WIDTH = 256,
    parameter int BUS_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BUS_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    input  logic [2:0]            in_mode,
    input  logic                  in_hi,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [SIMD_WIDTH-1:0] op_a,
    output logic [SIMD_WIDTH-1:0] op_b,
    output logic [2:0]            op_mode,
    output logic                  op_hi,
    output logic                  err
);
    localparam int BEATS = SIMD_WIDTH / BUS_WIDTH;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   a_q [BEATS];
    logic [BUS_WIDTH-1:0]   b_q [BEATS];
    logic [2:0]             mode_q;
    logic                   hi_q;
    logic [SIMD_WIDTH-1:0]  a_flat, b_flat;
    logic [SIMD_WIDTH-1:0]  op_a_q, op_b_q;
    logic [2:0]             op_mode_q;
    logic                   op_hi_q, op_valid_q, err_q;

    logic accept, last_beat, frame_end, frame_err, handshake;

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt_q == LAST_CNT);
    assign frame_end = (state_q == LOAD_B) && last_beat;
    assign frame_err = accept && (in_last != frame_end);
    assign handshake = op_valid_q && op_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (frame_err) begin
                        state_d = LOAD_A;
                        cnt_d   = '0;
                    end else if (last_beat) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : PRESENT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (handshake) state_d = LOAD_A;
            end
            default: begin
                state_d = LOAD_A;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready = rst_n && (state_q != PRESENT);
    end

    // The final B beat is folded in directly so the presented set is complete on the transition edge.
    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int k = 0; k < BEATS; k++) begin
            a_flat[k*BUS_WIDTH +: BUS_WIDTH] = a_q[k];
            b_flat[k*BUS_WIDTH +: BUS_WIDTH] = (k == int'(cnt_q)) ? in_data : b_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < BEATS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            mode_q     <= '0;
            hi_q       <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_mode_q  <= '0;
            op_hi_q    <= 1'b0;
            op_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= frame_err;
            if (handshake) op_valid_q <= 1'b0;
            if (accept && !frame_err) begin
                if (state_q == LOAD_A) begin
                    a_q[cnt_q] <= in_data;
                    if (cnt_q == '0) begin
                        mode_q <= in_mode;
                        hi_q   <= in_hi;
                    end
                end else begin
                    b_q[cnt_q] <= in_data;
                end
                if (frame_end) begin
                    op_a_q     <= a_flat;
                    op_b_q     <= b_flat;
                    op_mode_q  <= mode_q;
                    op_hi_q    <= hi_q;
                    op_valid_q <= 1'b1;
                end
            end
        end
    end

    assign op_valid = op_valid_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_mode  = op_mode_q;
    assign op_hi    = op_hi_q;
    assign err      = err_q;
endmodule

// File: tb/tb_simd_operand_loader.sv
// tb/tb_simd_operand_loader.sv - scoreboard bench for simd_operand_loader
module tb_simd_operand_loader;
    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, in_last, in_hi;
    logic [63:0]  in_data;
    logic [2:0]   in_mode, op_mode;
    logic         op_valid, op_ready, op_hi, err;
    logic [255:0] op_a, op_b;

    simd_operand_loader #(.SIMD_WIDTH(256), .BUS_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_mode(in_mode), .in_hi(in_hi),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .op_mode(op_mode), .op_hi(op_hi), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [255:0] a;
        logic [255:0] b;
        logic [2:0]   mode;
        logic         hi;
    } set_t;

    set_t        exp_q[$];
    set_t        mon_e;
    set_t        e_bp, e_last;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          err_pending = 0;
    logic        prev_hs = 1'b0;
    logic [63:0] cur [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops one expected set; every err pulse must have been announced.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hs) check("op_valid_drop", op_valid, 0);
            if (op_valid && op_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_set: got a=%h want none", op_a);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("op_a", op_a, mon_e.a);
                    check("op_b", op_b, mon_e.b);
                    check("op_mode", op_mode, mon_e.mode);
                    check("op_hi", op_hi, mon_e.hi);
                end
            end
            if (err) begin
                n_cmp++;
                if (err_pending == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_err: got 1 want 0");
                end else begin
                    err_pending--;
                end
            end
            prev_hs = op_valid && op_ready;
        end else begin
            prev_hs = 1'b0;
        end
    end

    function automatic set_t pack(input logic [2:0] m, input logic h);
        set_t s;
        s.a    = {cur[3], cur[2], cur[1], cur[0]};
        s.b    = {cur[7], cur[6], cur[5], cur[4]};
        s.mode = m;
        s.hi   = h;
        return s;
    endfunction

    task automatic fill(input logic [63:0] base);
        for (int i = 0; i < 4; i++) cur[i] = base + 64'(i);
        for (int i = 4; i < 8; i++) cur[i] = base + 64'h10 + 64'(i - 4);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input int gap);
        int t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // kind: 0 good set, 1 early last on beat 3, 2 missing last on beat 8, 3 stop after beat 5
    task automatic send_set(input logic [2:0] mode, input logic hi, input int gap,
                            input int kind, input int first);
        logic last;
        for (int i = first; i < 8; i++) begin
            last = (i == 7);
            if (kind == 1 && i == 2) last = 1'b1;
            if (kind == 2 && i == 7) last = 1'b0;
            if (i == 0) begin
                in_mode = mode;
                in_hi   = hi;
            end
            send_beat(cur[i], last, (i == 0) ? 0 : gap);
            in_mode = ~mode;
            in_hi   = ~hi;
            if ((kind == 1 && i == 2) || (kind == 2 && i == 7)) err_pending++;
            if ((kind == 1 && i == 2) || (kind == 3 && i == 4)) break;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'hdead_beef;
        in_last  = 1'b1;
        in_mode  = 3'd6;
        in_hi    = 1'b1;
        op_ready = 1'b1;

        // Reset held two cycles with in_valid high
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 0);
            check("rst_op_valid", op_valid, 0);
            check("rst_op_a", op_a, 0);
            check("rst_op_b", op_b, 0);
            check("rst_op_mode", op_mode, 0);
            check("rst_op_hi", op_hi, 0);
            check("rst_err", err, 0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Back-to-back load
        cur[0] = 64'h1;  cur[1] = 64'h2;  cur[2] = 64'h3;  cur[3] = 64'h4;
        cur[4] = 64'h10; cur[5] = 64'h11; cur[6] = 64'h12; cur[7] = 64'h13;
        exp_q.push_back('{a: {64'h4, 64'h3, 64'h2, 64'h1},
                          b: {64'h13, 64'h12, 64'h11, 64'h10}, mode: 3'd2, hi: 1'b1});
        send_set(3'd2, 1'b1, 0, 0, 0);
        @(negedge clk);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: hold op_ready low 5 cycles with the next beat 0 waiting
        fill(64'h100);
        op_ready = 1'b0;
        e_bp = pack(3'd5, 1'b0);
        exp_q.push_back(e_bp);
        send_set(3'd5, 1'b0, 0, 0, 0);
        fill(64'h200);
        in_valid = 1'b1;
        in_data  = cur[0];
        in_last  = 1'b0;
        in_mode  = 3'd3;
        in_hi    = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_op_valid", op_valid, 1);
            check("bp_op_a", op_a, e_bp.a);
            check("bp_op_b", op_b, e_bp.b);
            check("bp_op_mode", op_mode, e_bp.mode);
        end
        @(posedge clk);
        #1;
        op_ready = 1'b1;
        exp_q.push_back(pack(3'd3, 1'b1));
        @(posedge clk);
        @(negedge clk);
        check("after_hs_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 3'd0;
        in_hi    = 1'b0;
        send_set(3'd3, 1'b1, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;

        // Framing error: in_last on beat 3
        fill(64'h300);
        send_set(3'd0, 1'b0, 0, 1, 0);
        repeat (2) begin
            @(negedge clk);
            check("early_last_op_valid", op_valid, 0);
        end
        @(posedge clk);
        #1;
        fill(64'h400);
        e_last = pack(3'd4, 1'b1);
        exp_q.push_back(e_last);
        send_set(3'd4, 1'b1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Framing error: in_last missing on beat 8; last consumed set must remain on op_*
        fill(64'h500);
        send_set(3'd1, 1'b0, 0, 2, 0);
        repeat (2) begin
            @(negedge clk);
            check("miss_last_op_valid", op_valid, 0);
            check("miss_last_op_a", op_a, e_last.a);
            check("miss_last_op_mode", op_mode, e_last.mode);
        end
        @(posedge clk);
        #1;

        // Gaps between beats give the same result as back-to-back
        cur[0] = 64'h1;  cur[1] = 64'h2;  cur[2] = 64'h3;  cur[3] = 64'h4;
        cur[4] = 64'h10; cur[5] = 64'h11; cur[6] = 64'h12; cur[7] = 64'h13;
        exp_q.push_back('{a: {64'h4, 64'h3, 64'h2, 64'h1},
                          b: {64'h13, 64'h12, 64'h11, 64'h10}, mode: 3'd2, hi: 1'b1});
        send_set(3'd2, 1'b1, 2, 0, 0);
        repeat (3) @(posedge clk);
        #1;

        // Mid-load reset after beat 5, then a fresh set with passthrough mode
        fill(64'h700);
        send_set(3'd7, 1'b1, 0, 3, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_op_valid", op_valid, 0);
        check("midrst_op_a", op_a, 0);
        @(posedge clk);
        #1;
        fill(64'h800);
        exp_q.push_back(pack(3'd7, 1'b0));
        send_set(3'd7, 1'b0, 1, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        check("sets_outstanding", exp_q.size(), 0);
        check("errs_outstanding", err_pending, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
